// File: rtl/wts_wave_ram_arbiter_pkg.sv
// wts_wave_ram_arbiter_pkg: shared FSM states, grant owners and wave-table geometry.
package wts_wave_ram_arbiter_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;
    typedef enum logic {GRANT_CPU, GRANT_SND} grant_t;
    localparam int WAVE_LEN = 32;
endpackage

// File: rtl/wts_wave_ram_arbiter_if.sv
// wts_wave_ram_arbiter_if: CPU slot-bus, tone-generator fetch and RAM macro signals.
interface wts_wave_ram_arbiter_if #(parameter int DATA_W = 8);
    logic              cpu_wrreq;
    logic              cpu_rdreq;
    logic [7:0]        cpu_a;
    logic [DATA_W-1:0] cpu_d;
    logic [DATA_W-1:0] cpu_q;
    logic              cpu_q_valid;
    logic              cpu_overrun;
    logic              snd_req;
    logic [2:0]        snd_ch;
    logic [4:0]        snd_idx;
    logic              snd_ack;
    logic [DATA_W-1:0] snd_q;
    logic [7:0]        ram_a;
    logic              ram_we;
    logic [DATA_W-1:0] ram_d;
    logic [DATA_W-1:0] ram_q;
    modport master (
        output cpu_wrreq, cpu_rdreq, cpu_a, cpu_d, snd_req, snd_ch, snd_idx, ram_q,
        input  cpu_q, cpu_q_valid, cpu_overrun, snd_ack, snd_q, ram_a, ram_we, ram_d
    );
    modport slave (
        input  cpu_wrreq, cpu_rdreq, cpu_a, cpu_d, snd_req, snd_ch, snd_idx, ram_q,
        output cpu_q, cpu_q_valid, cpu_overrun, snd_ack, snd_q, ram_a, ram_we, ram_d
    );
endinterface

// File: rtl/wts_wave_ram_arbiter_req_latch.sv
// wts_wave_ram_arbiter_req_latch: one-deep capture of CPU strobes with sticky overrun.
module wts_wave_ram_arbiter_req_latch #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_wrreq,
    input  logic              i_rdreq,
    input  logic              i_clr,
    input  logic [7:0]        i_a,
    input  logic [DATA_W-1:0] i_d,
    output logic              o_pend,
    output logic              o_wr,
    output logic              o_overrun,
    output logic [7:0]        o_a,
    output logic [DATA_W-1:0] o_d
);
    logic              r_pend, r_wr, r_ovr;
    logic [7:0]        r_a;
    logic [DATA_W-1:0] r_d;
    logic              w_stb;
    assign w_stb = i_wrreq | i_rdreq;
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            r_pend <= 1'b0;
            r_wr   <= 1'b0;
            r_ovr  <= 1'b0;
            r_a    <= '0;
            r_d    <= '0;
        end else begin
            if (w_stb && !r_pend) begin
                r_pend <= 1'b1;
                r_wr   <= i_wrreq;
                r_a    <= i_a;
                r_d    <= i_d;
            end else if (i_clr)
                r_pend <= 1'b0;
            // a colliding read is lost to the write, so it counts as an overrun too
            if ((w_stb && r_pend) || (i_wrreq && i_rdreq))
                r_ovr <= 1'b1;
        end
    assign o_pend    = r_pend;
    assign o_wr      = r_wr;
    assign o_overrun = r_ovr;
    assign o_a       = r_a;
    assign o_d       = r_d;
endmodule

// File: rtl/wts_wave_ram_arbiter.sv
// wts_wave_ram_arbiter: round-robin sharing of the wave-table RAM between the CPU slot bus
// and the tone generator's sample fetch, with registered RAM controls and fixed latency.
module wts_wave_ram_arbiter
    import wts_wave_ram_arbiter_pkg::*;
#(
    parameter int CH_NUM = 5,
    parameter int DATA_W = 8
) (
    input logic                   clk,
    input logic                   reset,
    wts_wave_ram_arbiter_if.slave bus
);
    logic              w_pend, w_wr, w_ovr, w_edge, w_snd_cand, w_gnt_cpu, w_gnt_snd;
    logic              w_cpu_ok, w_snd_ok;
    logic [7:0]        w_a;
    logic [DATA_W-1:0] w_d;
    state_t            r_state, w_next;
    grant_t            r_last;
    logic              r_cur_rd, r_cur_ok, r_ram_we, r_cpu_q_valid, r_snd_ack;
    logic [7:0]        r_ram_a;
    logic [DATA_W-1:0] r_ram_d, r_cpu_q, r_snd_q;

    wts_wave_ram_arbiter_req_latch #(.DATA_W(DATA_W)) u_req (
        .clk(clk), .reset(reset),
        .i_wrreq(bus.cpu_wrreq), .i_rdreq(bus.cpu_rdreq), .i_clr(w_gnt_cpu),
        .i_a(bus.cpu_a), .i_d(bus.cpu_d),
        .o_pend(w_pend), .o_wr(w_wr), .o_overrun(w_ovr), .o_a(w_a), .o_d(w_d)
    );

    always_comb begin
        w_edge     = r_state == ST_IDLE || r_state == ST_WAIT;
        // the fetch in flight, or one acked last cycle, is not a new request
        w_snd_cand = bus.snd_req && !r_snd_ack && !(r_state == ST_WAIT && r_last == GRANT_SND);
        w_gnt_cpu  = w_edge && w_pend && (!w_snd_cand || r_last == GRANT_SND);
        w_gnt_snd  = w_edge && w_snd_cand && !w_gnt_cpu;
        w_next     = (w_gnt_cpu || w_gnt_snd) ? ST_ISSUE : r_state == ST_ISSUE ? ST_WAIT : ST_IDLE;
        w_cpu_ok   = int'(w_a) < CH_NUM * WAVE_LEN;
        w_snd_ok   = int'(bus.snd_ch) < CH_NUM;
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            r_last        <= GRANT_SND;
            r_cur_rd      <= 1'b0;
            r_cur_ok      <= 1'b0;
            r_ram_we      <= 1'b0;
            r_ram_a       <= '0;
            r_ram_d       <= '0;
            r_cpu_q       <= '0;
            r_cpu_q_valid <= 1'b0;
            r_snd_ack     <= 1'b0;
            r_snd_q       <= '0;
        end else begin
            r_cpu_q_valid <= 1'b0;
            r_snd_ack     <= 1'b0;
            if (r_state == ST_ISSUE) r_ram_we <= 1'b0;
            if (r_state == ST_WAIT && r_last == GRANT_CPU && r_cur_rd) begin
                r_cpu_q       <= r_cur_ok ? bus.ram_q : '0;
                r_cpu_q_valid <= 1'b1;
            end
            if (r_state == ST_WAIT && r_last == GRANT_SND && bus.snd_req) begin
                r_snd_q   <= r_cur_ok ? bus.ram_q : '0;
                r_snd_ack <= 1'b1;
            end
            // out-of-range accesses still take the slot but leave the RAM port untouched
            if (w_gnt_cpu) begin
                r_last   <= GRANT_CPU;
                r_cur_rd <= !w_wr;
                r_cur_ok <= w_cpu_ok;
                r_ram_we <= w_wr && w_cpu_ok;
                if (w_cpu_ok) begin
                    r_ram_a <= w_a;
                    r_ram_d <= w_d;
                end
            end
            if (w_gnt_snd) begin
                r_last   <= GRANT_SND;
                r_cur_rd <= 1'b0;
                r_cur_ok <= w_snd_ok;
                r_ram_we <= 1'b0;
                if (w_snd_ok) r_ram_a <= {bus.snd_ch, bus.snd_idx};
            end
        end

    assign bus.ram_a       = r_ram_a;
    assign bus.ram_we      = r_ram_we;
    assign bus.ram_d       = r_ram_d;
    assign bus.cpu_q       = r_cpu_q;
    assign bus.cpu_q_valid = r_cpu_q_valid;
    assign bus.cpu_overrun = w_ovr;
    assign bus.snd_ack     = r_snd_ack;
    assign bus.snd_q       = r_snd_q;
endmodule

// File: tb/tb_wts_wave_ram_arbiter.sv
// tb_wts_wave_ram_arbiter: scenario tasks plus randomized contention against a memory-image model.
module tb_wts_wave_ram_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int total = 0;
    int bad = 0;
    logic [7:0] ref_mem [256];
    logic [7:0] ram_mem [256];
    bit         ram_wr [256];

    always #5 clk = ~clk;

    wts_wave_ram_arbiter_if #(.DATA_W(8)) bus ();
    wts_wave_ram_arbiter #(.CH_NUM(5), .DATA_W(8)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

    function automatic logic [7:0] init_val(int i);
        return 8'(i * 37 + 11);
    endfunction

    // RAM macro: write and read both sample the registered address; data valid one clock later
    always @(posedge clk) begin
        if (bus.ram_we) begin
            ram_mem[bus.ram_a] <= bus.ram_d;
            ram_wr[bus.ram_a]  <= 1'b1;
        end
        bus.ram_q <= ram_wr[bus.ram_a] ? ram_mem[bus.ram_a] : init_val(int'(bus.ram_a));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_stb(bit wr, logic [7:0] a, logic [7:0] d);
        bus.cpu_wrreq = wr;
        bus.cpu_rdreq = !wr;
        bus.cpu_a     = a;
        bus.cpu_d     = d;
        tick();
        bus.cpu_wrreq = 1'b0;
        bus.cpu_rdreq = 1'b0;
        if (wr && a < 8'd160) ref_mem[a] = d;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        total++;
        if ({bus.ram_we, bus.ram_a, bus.ram_d} !== 17'h0) begin
            bad++;
            $display("FAIL reset_ram: got we=%b a=%h d=%h want 0", bus.ram_we, bus.ram_a, bus.ram_d);
        end
        total++;
        if ({bus.cpu_q, bus.cpu_q_valid, bus.cpu_overrun, bus.snd_ack, bus.snd_q} !== 19'h0) begin
            bad++;
            $display("FAIL reset_out: got q=%h v=%b ovr=%b ack=%b sq=%h want 0",
                     bus.cpu_q, bus.cpu_q_valid, bus.cpu_overrun, bus.snd_ack, bus.snd_q);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_cpu_write();
        int acks = 0;
        cpu_stb(1'b1, 8'h25, 8'hA5);
        total++;
        if (bus.ram_we !== 1'b0) begin bad++; $display("FAIL wr_e0_we: got %b want 0", bus.ram_we); end
        tick();
        acks += int'(bus.snd_ack);
        total++;
        if ({bus.ram_we, bus.ram_a, bus.ram_d} !== {1'b1, 8'h25, 8'hA5}) begin
            bad++;
            $display("FAIL wr_e1: got we=%b a=%h d=%h want 1 25 a5", bus.ram_we, bus.ram_a, bus.ram_d);
        end
        tick();
        acks += int'(bus.snd_ack);
        total++;
        if (bus.ram_we !== 1'b0) begin bad++; $display("FAIL wr_e2_we: got %b want 0", bus.ram_we); end
        repeat (2) begin tick(); acks += int'(bus.snd_ack); end
        total++;
        if (acks != 0) begin bad++; $display("FAIL wr_no_ack: got %0d acks want 0", acks); end
    endtask

    task automatic test_write_read();
        cpu_stb(1'b1, 8'h41, 8'h3C);
        repeat (3) tick();
        cpu_stb(1'b0, 8'h41, 8'h00);
        tick();
        tick();
        total++;
        if (bus.cpu_q_valid !== 1'b0) begin bad++; $display("FAIL rd_e2_valid: got %b want 0", bus.cpu_q_valid); end
        tick();
        total++;
        if ({bus.cpu_q_valid, bus.cpu_q} !== {1'b1, 8'h3C}) begin
            bad++;
            $display("FAIL rd_e3: got v=%b q=%h want 1 3c", bus.cpu_q_valid, bus.cpu_q);
        end
        tick();
        total++;
        if ({bus.cpu_q_valid, bus.cpu_q} !== {1'b0, 8'h3C}) begin
            bad++;
            $display("FAIL rd_hold: got v=%b q=%h want 0 3c", bus.cpu_q_valid, bus.cpu_q);
        end
        tick();
    endtask

    task automatic test_snd_fetch();
        bit we_seen = 1'b0;
        bus.snd_ch  = 3'd2;
        bus.snd_idx = 5'd1;
        bus.snd_req = 1'b1;
        tick();
        tick();
        total++;
        if (bus.snd_ack !== 1'b0) begin bad++; $display("FAIL snd_e1_ack: got %b want 0", bus.snd_ack); end
        tick();
        total++;
        if ({bus.snd_ack, bus.snd_q} !== {1'b1, ref_mem[8'h41]}) begin
            bad++;
            $display("FAIL snd_e2: got ack=%b q=%h want 1 %h", bus.snd_ack, bus.snd_q, ref_mem[8'h41]);
        end
        bus.snd_req = 1'b0;
        tick();
        total++;
        if (bus.snd_ack !== 1'b0) begin bad++; $display("FAIL snd_ack_pulse: got %b want 0", bus.snd_ack); end
        tick();
        bus.snd_ch  = 3'd6;
        bus.snd_idx = 5'd0;
        bus.snd_req = 1'b1;
        repeat (2) begin tick(); we_seen |= bus.ram_we; end
        tick();
        we_seen |= bus.ram_we;
        total++;
        if ({bus.snd_ack, bus.snd_q} !== {1'b1, 8'h00}) begin
            bad++;
            $display("FAIL badch_ack: got ack=%b q=%h want 1 00", bus.snd_ack, bus.snd_q);
        end
        bus.snd_req = 1'b0;
        tick();
        we_seen |= bus.ram_we;
        total++;
        if ({we_seen, bus.ram_a} !== {1'b0, 8'h41}) begin
            bad++;
            $display("FAIL badch_ram: got we_seen=%b a=%h want 0 41", we_seen, bus.ram_a);
        end
        tick();
    endtask

    task automatic test_contention();
        int rd_edge = -1;
        int last_ack = 0;
        int acks = 0;
        bit prev_ack = 1'b0;
        logic [7:0] rd_exp = 8'h00;
        logic [7:0] snd_exp;
        logic [7:0] a;
        bus.snd_ch  = 3'($urandom_range(2, 7));
        bus.snd_idx = 5'($urandom_range(0, 31));
        snd_exp     = bus.snd_ch < 3'd5 ? ref_mem[{bus.snd_ch, bus.snd_idx}] : 8'h00;
        bus.snd_req = 1'b1;
        for (int cyc = 0; cyc < 150; cyc++) begin
            tick();
            if (bus.snd_ack) begin
                total++;
                if (bus.snd_q !== snd_exp || prev_ack) begin
                    bad++;
                    $display("FAIL cont_snd: got q=%h prev_ack=%b want %h 0", bus.snd_q, prev_ack, snd_exp);
                end
                acks++;
                last_ack    = cyc;
                bus.snd_ch  = 3'($urandom_range(2, 7));
                bus.snd_idx = 5'($urandom_range(0, 31));
                snd_exp     = bus.snd_ch < 3'd5 ? ref_mem[{bus.snd_ch, bus.snd_idx}] : 8'h00;
            end else if (cyc - last_ack > 8) begin
                total++;
                bad++;
                $display("FAIL cont_snd_timeout: got no ack for %0d clks want <=8", cyc - last_ack);
                last_ack = cyc;
            end
            prev_ack = bus.snd_ack;
            if (bus.cpu_q_valid) begin
                total++;
                if (bus.cpu_q !== rd_exp || rd_edge < 0 || cyc - rd_edge < 3 || cyc - rd_edge > 4) begin
                    bad++;
                    $display("FAIL cont_rd: got q=%h lat=%0d want %h lat 3..4", bus.cpu_q, cyc - rd_edge, rd_exp);
                end
                rd_edge = -1;
            end else if (rd_edge >= 0 && cyc - rd_edge > 4) begin
                total++;
                bad++;
                $display("FAIL cont_rd_timeout: got no valid after %0d clks want <=4", cyc - rd_edge);
                rd_edge = -1;
            end
            bus.cpu_wrreq = 1'b0;
            bus.cpu_rdreq = 1'b0;
            if (cyc % 6 == 0) begin
                if ($urandom_range(0, 1) == 1) begin
                    a = $urandom_range(0, 3) == 0 ? 8'($urandom_range(160, 255)) : 8'($urandom_range(0, 63));
                    bus.cpu_wrreq = 1'b1;
                    bus.cpu_a     = a;
                    bus.cpu_d     = 8'($urandom);
                    if (a < 8'd160) ref_mem[a] = bus.cpu_d;
                end else begin
                    a = 8'($urandom_range(0, 255));
                    bus.cpu_rdreq = 1'b1;
                    bus.cpu_a     = a;
                    rd_exp        = a < 8'd160 ? ref_mem[a] : 8'h00;
                    rd_edge       = cyc + 1;
                end
            end
        end
        bus.cpu_wrreq = 1'b0;
        bus.cpu_rdreq = 1'b0;
        bus.snd_req   = 1'b0;
        repeat (6) tick();
        total++;
        if (bus.cpu_overrun !== 1'b0 || acks < 20) begin
            bad++;
            $display("FAIL cont_summary: got ovr=%b acks=%0d want 0 >=20", bus.cpu_overrun, acks);
        end
    endtask

    task automatic test_overrun();
        int valids = 0;
        bus.snd_ch  = 3'd3;
        bus.snd_idx = 5'd2;
        bus.snd_req = 1'b1;
        cpu_stb(1'b1, 8'h12, 8'h5A);
        tick();
        cpu_stb(1'b0, 8'h12, 8'h00);
        total++;
        if ({bus.snd_ack, bus.snd_q, bus.cpu_overrun} !== {1'b1, ref_mem[8'h62], 1'b1}) begin
            bad++;
            $display("FAIL ovr_e2: got ack=%b q=%h ovr=%b want 1 %h 1",
                     bus.snd_ack, bus.snd_q, bus.cpu_overrun, ref_mem[8'h62]);
        end
        bus.snd_req = 1'b0;
        repeat (6) begin tick(); valids += int'(bus.cpu_q_valid); end
        total++;
        if (valids != 0 || bus.cpu_overrun !== 1'b1) begin
            bad++;
            $display("FAIL ovr_dropped: got valids=%0d ovr=%b want 0 1", valids, bus.cpu_overrun);
        end
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        bus.cpu_wrreq = 1'b1;
        bus.cpu_a     = 8'h30;
        bus.cpu_d     = 8'h99;
        tick();
        bus.cpu_wrreq = 1'b0;
        tick();
        total++;
        if (bus.ram_we !== 1'b1) begin bad++; $display("FAIL rstmid_issue: got we=%b want 1", bus.ram_we); end
        #1 reset = 1'b1;
        #1;
        total++;
        if ({bus.ram_we, bus.cpu_overrun} !== 2'b00) begin
            bad++;
            $display("FAIL rstmid_async: got we=%b ovr=%b want 0 0", bus.ram_we, bus.cpu_overrun);
        end
        tick();
        tick();
        reset = 1'b0;
        repeat (4) begin tick(); pulses += int'(bus.cpu_q_valid) + int'(bus.snd_ack) + int'(bus.ram_we); end
        total++;
        if (pulses != 0) begin bad++; $display("FAIL rstmid_quiet: got %0d pulses want 0", pulses); end
        cpu_stb(1'b0, 8'h30, 8'h00);
        tick();
        tick();
        tick();
        total++;
        if ({bus.cpu_q_valid, bus.cpu_q} !== {1'b1, ref_mem[8'h30]}) begin
            bad++;
            $display("FAIL rstmid_read: got v=%b q=%h want 1 %h", bus.cpu_q_valid, bus.cpu_q, ref_mem[8'h30]);
        end
        tick();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        bus.cpu_wrreq = 1'b0;
        bus.cpu_rdreq = 1'b0;
        bus.cpu_a     = 8'h00;
        bus.cpu_d     = 8'h00;
        bus.snd_req   = 1'b0;
        bus.snd_ch    = 3'd0;
        bus.snd_idx   = 5'd0;
        test_reset();
        test_cpu_write();
        test_write_read();
        test_snd_fetch();
        test_contention();
        test_overrun();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
